// File: rtl/spram_pkg.sv
// Shared constants, clear-engine state type and a constant clog2 helper
// for the banked SPRAM main memory.
package spram_pkg;

  localparam int SPRAM_WORD_AW    = 14;
  localparam int SPRAM_BANK_BYTES = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One 16K x 16 single-port RAM bank with nibble write mask. The behavioural
// model is used for simulation; synthesis maps onto the iCE40 UP5K SPRAM.
module spram_bank
  import spram_pkg::*;
(
  input  logic                     clk,
  input  logic                     cs,
  input  logic                     wren,
  input  logic [SPRAM_WORD_AW-1:0] addr,
  input  logic [15:0]              wdata,
  input  logic [3:0]               maskwren,
  output logic [15:0]              rdata
);

`ifdef SIMULATE
  logic [15:0] mem_q [0:(1 << SPRAM_WORD_AW)-1] = '{default: 16'h0000};
  logic [15:0] rdata_q;
  logic [15:0] bitmask_s;

  assign bitmask_s = {{4{maskwren[3]}}, {4{maskwren[2]}}, {4{maskwren[1]}}, {4{maskwren[0]}}};

  // Masked write, or synchronous read into the output register (held otherwise)
  always_ff @(posedge clk) begin
    if (cs && wren) begin
      mem_q[addr] <= (mem_q[addr] & ~bitmask_s) | (wdata & bitmask_s);
    end else if (cs) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;
`elsif SYNTHESIS
  SB_SPRAM256KA u_spram (
    .ADDRESS   (addr),
    .DATAIN    (wdata),
    .MASKWREN  (maskwren),
    .WREN      (wren),
    .CHIPSELECT(cs),
    .CLOCK     (clk),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (rdata)
  );
`else
  logic [15:0] mem_q [0:(1 << SPRAM_WORD_AW)-1] = '{default: 16'h0000};
  logic [15:0] rdata_q;
  logic [15:0] bitmask_s;

  assign bitmask_s = {{4{maskwren[3]}}, {4{maskwren[2]}}, {4{maskwren[1]}}, {4{maskwren[0]}}};

  // Masked write, or synchronous read into the output register (held otherwise)
  always_ff @(posedge clk) begin
    if (cs && wren) begin
      mem_q[addr] <= (mem_q[addr] & ~bitmask_s) | (wdata & bitmask_s);
    end else if (cs) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/spram_banked.sv
// Byte-wide main RAM over NBANKS SPRAM banks with region write protect,
// a qualified read-data path and a zero-fill clear engine.
module spram_banked
  import spram_pkg::*;
#(
  parameter int NBANKS       = 2,
  parameter int WP_BITS      = 8,
  parameter bit CLR_ON_RESET = 1'b0,
  parameter int ADDR_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic               we,
  input  logic [WP_BITS-1:0] wp,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               ready
);

  localparam int BANK_W    = (NBANKS > 1) ? clog2(NBANKS) : 1;
  localparam int WP_W      = clog2(WP_BITS);
  localparam int REG_W     = (WP_W > 0) ? WP_W : 1;
  localparam int REG_SHIFT = ADDR_W - WP_W;
  localparam logic [SPRAM_WORD_AW-1:0] LAST_WORD = 14'h3FFF;

  if (ADDR_W != 15 + clog2(NBANKS)) begin : g_bad_addr_w
    $error("spram_banked: ADDR_W must equal 15+clog2(NBANKS)");
  end

  // Region index is the top clog2(WP_BITS) address bits.
  function automatic logic region_protected(input logic [ADDR_W-1:0] a,
                                            input logic [WP_BITS-1:0] mask);
    logic [ADDR_W-1:0] region;
    region = a >> REG_SHIFT;
    return mask[region[REG_W-1:0]];
  endfunction

  clr_state_e               state_q, state_d;
  logic [SPRAM_WORD_AW-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic [BANK_W-1:0]        rd_bank_q, rd_bank_d;
  logic                     rd_lane_q, rd_lane_d;
  logic                     rd_valid_q, rd_valid_d;

  logic [BANK_W-1:0]        bank_s;
  logic                     mapped_s, cpu_wr_s, cpu_rd_s;
  logic [NBANKS-1:0]        cs_s;
  logic                     wren_s;
  logic [SPRAM_WORD_AW-1:0] word_s;
  logic [15:0]              wdata_s;
  logic [3:0]               mask_s;
  logic [15:0]              rdata_s [NBANKS];

  assign bank_s   = BANK_W'(addr >> 15);
  assign mapped_s = (int'(bank_s) < NBANKS);
  assign cpu_wr_s = sel && we && !busy_q && !region_protected(addr, wp);
  assign cpu_rd_s = sel && !we && !busy_q;
  assign clr_busy = busy_q;
  assign ready    = !busy_q;

  // Clear FSM next state: start only from IDLE, sweep every word once, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 14'd1;
        if (cnt_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Bank port steering: the clear engine owns all banks while busy, else CPU decode.
  // Protected clear words drop chip select so the bank output register is untouched.
  always_comb begin
    cs_s    = '0;
    wren_s  = 1'b0;
    word_s  = addr[14:1];
    wdata_s = {din, din};
    mask_s  = addr[0] ? 4'b1100 : 4'b0011;
    if (busy_q) begin
      wren_s  = 1'b1;
      word_s  = cnt_q;
      wdata_s = 16'h0000;
      mask_s  = 4'b1111;
      for (int b = 0; b < NBANKS; b++) begin
        cs_s[b] = (state_q == CLEAR) &&
                  !region_protected(ADDR_W'(b * SPRAM_BANK_BYTES + int'(cnt_q) * 2), wp);
      end
    end else begin
      wren_s = we;
      for (int b = 0; b < NBANKS; b++) begin
        cs_s[b] = (cpu_wr_s || cpu_rd_s) && mapped_s && (bank_s == BANK_W'(b));
      end
    end
  end

  // Read qualifier capture: remember which bank/lane the last accepted read targeted
  always_comb begin
    rd_bank_d  = rd_bank_q;
    rd_lane_d  = rd_lane_q;
    rd_valid_d = rd_valid_q;
    if (cpu_rd_s) begin
      rd_bank_d  = bank_s;
      rd_lane_d  = addr[0];
      rd_valid_d = 1'b1;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // Output lane select; unmapped banks never match and so read as zero
  always_comb begin
    dout = 8'h00;
    for (int b = 0; b < NBANKS; b++) begin
      if (rd_valid_q && (rd_bank_q == BANK_W'(b))) begin
        dout = rd_lane_q ? rdata_s[b][15:8] : rdata_s[b][7:0];
      end else begin
        dout = dout;
      end
    end
  end

  // State and read-qualifier registers; reset aborts any clear in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_ON_RESET ? CLEAR : IDLE;
      cnt_q      <= '0;
      busy_q     <= CLR_ON_RESET;
      rd_bank_q  <= '0;
      rd_lane_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rd_bank_q  <= rd_bank_d;
      rd_lane_q  <= rd_lane_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    spram_bank u_bank (
      .clk     (clk),
      .cs      (cs_s[b]),
      .wren    (wren_s),
      .addr    (word_s),
      .wdata   (wdata_s),
      .maskwren(mask_s),
      .rdata   (rdata_s[b])
    );
  end

endmodule

// File: tb/tb_spram_banked.sv
// Randomised and directed checks of spram_banked against a byte-array model.
module tb_spram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel, we, clr_start, clr_busy, ready;
  logic [7:0]  wp, din, dout;
  logic [15:0] addr;
  logic        reset1, sel1, we1, clr_start1, clr_busy1, ready1;
  logic [7:0]  wp1, din1, dout1;
  logic [14:0] addr1;

  spram_banked #(.NBANKS(2), .WP_BITS(8), .CLR_ON_RESET(1'b0), .ADDR_W(16)) u_dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .wp(wp), .addr(addr), .din(din),
    .dout(dout), .clr_start(clr_start), .clr_busy(clr_busy), .ready(ready)
  );

  spram_banked #(.NBANKS(1), .WP_BITS(8), .CLR_ON_RESET(1'b1), .ADDR_W(15)) u_dut1 (
    .clk(clk), .reset(reset1), .sel(sel1), .we(we1), .wp(wp1), .addr(addr1), .din(din1),
    .dout(dout1), .clr_start(clr_start1), .clr_busy(clr_busy1), .ready(ready1)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  mem_m [65536];
  logic [7:0]  exp_dout;
  logic [15:0] pool [48];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 64 KB split into 8 regions of 8 KB each.
  function automatic bit prot_m(input logic [15:0] a, input logic [7:0] mask);
    int r;
    r = int'(a) / 8192;
    return mask[r];
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 65536; a++) begin
      if (!prot_m(16'(a), wp)) mem_m[a] = 8'h00;
    end
  endtask

  // One CPU access on the main DUT while it is idle; dout must match the model afterwards.
  task automatic cpu_op(input bit is_wr, input logic [15:0] a, input logic [7:0] d);
    string tag;
    sel = 1'b1; we = is_wr; addr = a; din = d;
    step();
    sel = 1'b0; we = 1'b0;
    if (is_wr) begin
      if (!prot_m(a, wp)) mem_m[a] = d;
      tag = "dout_after_wr";
    end else begin
      exp_dout = mem_m[a];
      tag = "dout_after_rd";
    end
    check_eq(tag, dout, exp_dout);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ready_err, hold_err;
    logic [15:0] a;

    reset = 1'b1; sel = 1'b0; we = 1'b0; clr_start = 1'b0; wp = 8'h00; addr = '0; din = '0;
    reset1 = 1'b1; sel1 = 1'b0; we1 = 1'b0; clr_start1 = 1'b0; wp1 = 8'h00; addr1 = '0; din1 = '0;
    exp_dout = 8'h00;
    for (int i = 0; i < 65536; i++) mem_m[i] = 8'h00;
    for (int i = 0; i < 48; i++) pool[i] = 16'($urandom);
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'hDFFF; pool[3] = 16'hE000;
    pool[4] = 16'hFFFF; pool[5] = 16'h0010; pool[6] = 16'h8000; pool[7] = 16'h7FFF;

    repeat (3) step();
    check_eq("rst_busy", clr_busy, 0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_dout", dout, 0);
    check_eq("rst1_busy", clr_busy1, 1);
    check_eq("rst1_ready", ready1, 0);
    check_eq("rst1_dout", dout1, 0);
    reset = 1'b0;
    step();

    // Basic lanes and banks
    cpu_op(1'b1, 16'h0001, 8'hA5);
    cpu_op(1'b1, 16'h8000, 8'h5A);
    cpu_op(1'b0, 16'h0001, 8'h00); check_eq("rd_0001", dout, 8'hA5);
    cpu_op(1'b0, 16'h8000, 8'h00); check_eq("rd_8000", dout, 8'h5A);
    step();                          check_eq("dout_hold", dout, 8'h5A);
    cpu_op(1'b0, 16'h0000, 8'h00); check_eq("rd_0000", dout, 8'h00);

    // Region 0 protected
    wp = 8'h01;
    cpu_op(1'b1, 16'h0100, 8'h11);
    cpu_op(1'b1, 16'h2100, 8'h11);
    cpu_op(1'b0, 16'h0100, 8'h00); check_eq("rd_prot", dout, 8'h00);
    cpu_op(1'b0, 16'h2100, 8'h00); check_eq("rd_unprot", dout, 8'h11);

    // Random traffic with random protection masks
    for (int i = 0; i < 800; i++) begin
      wp = 8'($urandom) & 8'($urandom);
      a = pool[$urandom_range(0, 47)] ^ 16'($urandom_range(0, 1));
      cpu_op(1'($urandom_range(0, 1)), a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        step();
        check_eq("gap_hold", dout, exp_dout);
      end
    end

    // Fill sample addresses with FF, then clear with the top region protected
    wp = 8'h00;
    for (int i = 0; i < 48; i++) begin
      cpu_op(1'b1, pool[i], 8'hFF);
      cpu_op(1'b1, pool[i] ^ 16'h0001, 8'hFF);
    end
    wp = 8'h80;
    sel = 1'b1; we = 1'b0; addr = 16'hE000; clr_start = 1'b1;
    step();
    sel = 1'b0; clr_start = 1'b0;
    exp_dout = mem_m[16'hE000];
    check_eq("rd_with_start", dout, 8'hFF);
    check_eq("busy_after_start", clr_busy, 1);
    n = 0; ready_err = 0; hold_err = 0;
    while (clr_busy && n < 20000) begin
      if (ready !== 1'b0) ready_err++;
      if (dout !== exp_dout) hold_err++;
      if (n == 5) begin
        sel = 1'b1; we = 1'b1; addr = 16'h0010; din = 8'h77;
      end else if (n == 6) begin
        sel = 1'b1; we = 1'b0; addr = 16'h0000;
      end else begin
        sel = 1'b0; we = 1'b0;
      end
      n++;
      step();
    end
    sel = 1'b0; we = 1'b0;
    check_eq("clr_len", n, 16385);
    check_eq("clr_ready_low", ready_err, 0);
    check_eq("clr_dout_hold", hold_err, 0);
    check_eq("ready_after_clr", ready, 1);
    model_clear();
    cpu_op(1'b0, 16'h0010, 8'h00); check_eq("rd_0010_dropped", dout, 8'h00);
    cpu_op(1'b0, 16'hDFFF, 8'h00); check_eq("rd_DFFF_cleared", dout, 8'h00);
    cpu_op(1'b0, 16'hE000, 8'h00); check_eq("rd_E000_kept", dout, 8'hFF);
    for (int i = 0; i < 48; i++) cpu_op(1'b0, pool[i], 8'h00);

    // Reset aborts a clear; a new clear runs the full length
    wp = 8'h00;
    cpu_op(1'b0, 16'hFFFF, 8'h00);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (100) step();
    check_eq("busy_mid_clear", clr_busy, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_busy", clr_busy, 0);
    check_eq("abort_ready", ready, 1);
    check_eq("abort_dout", dout, 0);
    step();
    reset = 1'b0;
    exp_dout = 8'h00;
    step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 20000) begin
      n++;
      step();
    end
    check_eq("restart_len", n, 16385);
    model_clear();
    cpu_op(1'b0, 16'hE000, 8'h00); check_eq("rd_E000_cleared", dout, 8'h00);
    for (int i = 0; i < 16; i++) cpu_op(1'b0, pool[i], 8'h00);

    // Single bank, clear on reset release
    reset1 = 1'b0;
    n = 0; ready_err = 0; hold_err = 0;
    while (clr_busy1 && n < 20000) begin
      if (ready1 !== 1'b0) ready_err++;
      if (dout1 !== 8'h00) hold_err++;
      if (n == 10) begin
        sel1 = 1'b1; we1 = 1'b1; addr1 = 15'h0005; din1 = 8'h3C;
      end else if (n == 11) begin
        sel1 = 1'b1; we1 = 1'b0; addr1 = 15'h0005;
      end else begin
        sel1 = 1'b0; we1 = 1'b0;
      end
      n++;
      step();
    end
    check_eq("por_clr_len", n, 16385);
    check_eq("por_ready_low", ready_err, 0);
    check_eq("por_dout_zero", hold_err, 0);
    sel1 = 1'b1; we1 = 1'b1; addr1 = 15'h0004; din1 = 8'hC3;
    step();
    sel1 = 1'b1; we1 = 1'b0; addr1 = 15'h0004;
    step();
    check_eq("por_first_rd", dout1, 8'hC3);
    sel1 = 1'b1; we1 = 1'b0; addr1 = 15'h0005;
    step();
    sel1 = 1'b0;
    check_eq("por_wr_dropped", dout1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
